// File: rtl/ldtu_bsl_pkg.sv
// Shared definitions for the LDTU baseline estimator: FSM encoding, window sizes
// and accumulator width.
package ldtu_bsl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } bsl_state_e;

    localparam int unsigned WIN_16  = 16;
    localparam int unsigned WIN_32  = 32;
    localparam int unsigned WIN_64  = 64;
    localparam int unsigned WIN_128 = 128;

    // 12-bit samples, up to 128 of them
    localparam int unsigned ACC_W = 19;

    // Index of the last sample in a window of 2^(n+4) samples
    function automatic logic [6:0] win_last(input logic [1:0] n);
        logic [6:0] last;
        case (n)
            2'd0:    last = 7'(WIN_16 - 1);
            2'd1:    last = 7'(WIN_32 - 1);
            2'd2:    last = 7'(WIN_64 - 1);
            2'd3:    last = 7'(WIN_128 - 1);
            default: last = 7'(WIN_16 - 1);
        endcase
        return last;
    endfunction

endpackage

// File: rtl/ldtu_bsl_round_sat.sv
// Round-half-up average of a window accumulator, saturated to 8 bits.
// Purely combinational; shared by both gain-channel instances.
module ldtu_bsl_round_sat
    import ldtu_bsl_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    input  logic [1:0]       n_i,
    output logic [7:0]       val_o,
    output logic             sat_o
);

    logic [ACC_W:0] sum_s;
    logic [ACC_W:0] avg_s;

    // Add half an LSB of the window, divide by the window length, then clip
    always_comb begin
        sum_s = {1'b0, acc_i};
        avg_s = '0;
        case (n_i)
            2'd0: begin
                sum_s = {1'b0, acc_i} + 20'd8;
                avg_s = sum_s >> 4'd4;
            end
            2'd1: begin
                sum_s = {1'b0, acc_i} + 20'd16;
                avg_s = sum_s >> 4'd5;
            end
            2'd2: begin
                sum_s = {1'b0, acc_i} + 20'd32;
                avg_s = sum_s >> 4'd6;
            end
            2'd3: begin
                sum_s = {1'b0, acc_i} + 20'd64;
                avg_s = sum_s >> 4'd7;
            end
            default: begin
                sum_s = {1'b0, acc_i};
                avg_s = '0;
            end
        endcase
        if (avg_s > 20'd255) begin
            val_o = 8'hFF;
            sat_o = 1'b1;
        end else begin
            val_o = avg_s[7:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/ldtu_bsl_estimator.sv
// Per-gain-channel pedestal estimator: averages a window of quiet ADC samples
// into an 8-bit baseline, with manual override and noisy-window flag.
module ldtu_bsl_estimator
    import ldtu_bsl_pkg::*;
#(
    parameter int unsigned          Nbits_12  = 12,
    parameter int unsigned          Nbits_8   = 8,
    parameter int unsigned          SKIP      = 4,
    parameter logic [Nbits_12-1:0]  NOISE_THR = 12'd16
) (
    input  logic                DCLK,
    input  logic                reset_,
    input  logic [Nbits_12-1:0] DATA12,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          win_sel,
    input  logic                man_en,
    input  logic [Nbits_8-1:0]  BSL_MAN,
    output logic [Nbits_8-1:0]  BSL_VAL,
    output logic                bsl_done,
    output logic                busy,
    output logic                bsl_sat,
    output logic                bsl_noisy
);

    bsl_state_e          state_q, state_d;
    logic [1:0]          n_q, n_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [Nbits_12-1:0] min_q, min_d;
    logic [Nbits_12-1:0] max_q, max_d;
    logic [Nbits_8-1:0]  bsl_val_q, bsl_val_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                sat_q, sat_d;
    logic                noisy_q, noisy_d;

    logic [7:0]          rs_val_s;
    logic                rs_sat_s;

    ldtu_bsl_round_sat u_round_sat (
        .acc_i (acc_q),
        .n_i   (n_q),
        .val_o (rs_val_s),
        .sat_o (rs_sat_s)
    );

    // Next-state logic: window sequencing, accumulation, result capture
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        min_d     = min_q;
        max_d     = max_q;
        bsl_val_d = bsl_val_q;
        done_d    = 1'b0;
        sat_d     = sat_q;
        noisy_d   = noisy_q;

        case (state_q)
            ST_IDLE: begin
                if (!man_en && start && !abort) begin
                    n_d   = win_sel;
                    cnt_d = 7'd0;
                    acc_d = '0;
                    min_d = '1;
                    max_d = '0;
                    if (SKIP > 0) begin
                        state_d = ST_SKIP;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SKIP: begin
                if (cnt_q == 7'(SKIP - 1)) begin
                    cnt_d   = 7'd0;
                    state_d = ST_ACCUM;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + ACC_W'(DATA12);
                if (DATA12 < min_q) begin
                    min_d = DATA12;
                end else begin
                    min_d = min_q;
                end
                if (DATA12 > max_q) begin
                    max_d = DATA12;
                end else begin
                    max_d = max_q;
                end
                if (cnt_q == win_last(n_q)) begin
                    cnt_d   = 7'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_DONE: begin
                bsl_val_d = rs_val_s;
                sat_d     = rs_sat_s;
                noisy_d   = (max_q - min_q) > NOISE_THR;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Manual mode and abort both cancel any estimate without a result
        if (man_en) begin
            state_d   = ST_IDLE;
            bsl_val_d = BSL_MAN;
            done_d    = 1'b0;
            sat_d     = sat_q;
            noisy_d   = noisy_q;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            bsl_val_d = bsl_val_q;
            done_d    = 1'b0;
            sat_d     = sat_q;
            noisy_d   = noisy_q;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge DCLK) begin
        if (!reset_) begin
            state_q   <= ST_IDLE;
            n_q       <= 2'd0;
            cnt_q     <= 7'd0;
            acc_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            bsl_val_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sat_q     <= 1'b0;
            noisy_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            min_q     <= min_d;
            max_q     <= max_d;
            bsl_val_q <= bsl_val_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            sat_q     <= sat_d;
            noisy_q   <= noisy_d;
        end
    end

    assign BSL_VAL   = bsl_val_q;
    assign bsl_done  = done_q;
    assign busy      = busy_q;
    assign bsl_sat   = sat_q;
    assign bsl_noisy = noisy_q;

endmodule

// File: tb/tb_ldtu_bsl_estimator.sv
// Self-checking bench for ldtu_bsl_estimator: directed scenarios plus random
// windows compared against an arithmetic average/peak-to-peak reference.
module tb_ldtu_bsl_estimator;

    localparam int SKIP = 4;
    localparam int THR  = 16;

    logic        DCLK = 1'b0;
    logic        reset_;
    logic [11:0] DATA12;
    logic        start;
    logic        abort;
    logic [1:0]  win_sel;
    logic        man_en;
    logic [7:0]  BSL_MAN;
    logic [7:0]  BSL_VAL;
    logic        bsl_done;
    logic        busy;
    logic        bsl_sat;
    logic        bsl_noisy;

    int n_vec = 0;
    int n_err = 0;

    int exp_val   = 0;
    int exp_sat   = 0;
    int exp_noisy = 0;

    ldtu_bsl_estimator #(.SKIP(SKIP)) dut (
        .DCLK      (DCLK),
        .reset_    (reset_),
        .DATA12    (DATA12),
        .start     (start),
        .abort     (abort),
        .win_sel   (win_sel),
        .man_en    (man_en),
        .BSL_MAN   (BSL_MAN),
        .BSL_VAL   (BSL_VAL),
        .bsl_done  (bsl_done),
        .busy      (busy),
        .bsl_sat   (bsl_sat),
        .bsl_noisy (bsl_noisy)
    );

    always #5 DCLK = ~DCLK;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_val"},   int'(BSL_VAL),   exp_val);
        check_eq({tag, "_sat"},   int'(bsl_sat),   exp_sat);
        check_eq({tag, "_noisy"}, int'(bsl_noisy), exp_noisy);
    endtask

    // kind 0: constant a; 1: alternating a/b; 2: uniform random in [a,b]
    task automatic run_est(input logic [1:0] ws, input int kind, input int a,
                           input int b, input bit dup_start);
        int len, sum, mn, mx, s, avg;
        len = 16 << ws;
        sum = 0;
        mn  = 4095;
        mx  = 0;
        win_sel = ws;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", int'(busy), 1);
        for (int i = 0; i < SKIP; i++) begin
            DATA12 = 12'($urandom);
            tick();
            check_eq("hold_in_skip", int'(BSL_VAL), exp_val);
        end
        for (int i = 0; i < len; i++) begin
            case (kind)
                0:       s = a;
                1:       s = (i % 2 == 0) ? a : b;
                default: s = int'($urandom_range(b, a));
            endcase
            DATA12  = s[11:0];
            sum    += s;
            if (s < mn) mn = s;
            if (s > mx) mx = s;
            win_sel = 2'($urandom);
            start   = dup_start && (i == 3);
            tick();
            start = 1'b0;
            check_eq("no_done_mid", int'(bsl_done), 0);
            check_eq("busy_mid", int'(busy), 1);
            check_eq("hold_mid", int'(BSL_VAL), exp_val);
        end
        tick();
        avg       = (sum + len / 2) / len;
        exp_sat   = (avg > 255) ? 1 : 0;
        exp_val   = (avg > 255) ? 255 : avg;
        exp_noisy = ((mx - mn) > THR) ? 1 : 0;
        check_eq("done_pulse", int'(bsl_done), 1);
        check_eq("busy_end", int'(busy), 0);
        check_outputs("result");
        tick();
        check_eq("done_one_cycle", int'(bsl_done), 0);
        check_outputs("result_hold");
    endtask

    initial begin
        int ra, rb;
        reset_  = 1'b0;
        DATA12  = 12'd0;
        start   = 1'b0;
        abort   = 1'b0;
        win_sel = 2'd0;
        man_en  = 1'b0;
        BSL_MAN = 8'd0;
        tick();
        tick();
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(bsl_done), 0);
        check_outputs("rst");
        reset_ = 1'b1;
        tick();

        run_est(2'd0, 0, 200, 200, 1'b0);
        run_est(2'd3, 1, 100, 101, 1'b0);
        run_est(2'd3, 1, 100, 130, 1'b0);
        run_est(2'd0, 0, 320, 320, 1'b0);
        run_est(2'd0, 0, 50, 50, 1'b0);
        run_est(2'd1, 0, 4095, 4095, 1'b0);
        run_est(2'd2, 2, 10, 60, 1'b1);

        // Abort at E10 discards the estimate
        win_sel = 2'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            DATA12 = 12'd900;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_done", int'(bsl_done), 0);
        check_outputs("abort");
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("abort_no_done", int'(bsl_done), 0);
            check_eq("abort_idle", int'(busy), 0);
        end

        // start together with abort in IDLE does not start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_abort_busy", int'(busy), 0);

        // Manual override mid-estimate
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        man_en  = 1'b1;
        BSL_MAN = 8'h3C;
        check_eq("man_delay", int'(BSL_VAL), exp_val);
        tick();
        exp_val = 8'h3C;
        check_eq("man_abort_busy", int'(busy), 0);
        check_outputs("man");
        start   = 1'b1;
        BSL_MAN = 8'h55;
        tick();
        start = 1'b0;
        exp_val = 8'h55;
        check_eq("man_start_ignored", int'(busy), 0);
        check_outputs("man2");
        man_en  = 1'b0;
        BSL_MAN = 8'h99;
        tick();
        tick();
        check_outputs("man_exit_hold");
        check_eq("man_exit_idle", int'(busy), 0);

        // Reset at E12 of an estimate
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        exp_val   = 0;
        exp_sat   = 0;
        exp_noisy = 0;
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_done", int'(bsl_done), 0);
        check_outputs("midrst");
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("midrst_no_done", int'(bsl_done), 0);
        end
        run_est(2'd0, 0, 77, 77, 1'b0);

        // Random windows
        for (int r = 0; r < 6; r++) begin
            ra = int'($urandom_range(400, 0));
            rb = ra + int'($urandom_range(40, 0));
            run_est(2'($urandom), int'($urandom_range(2, 0)), ra, rb, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
